// File: rtl/count_stream_decoder.sv
// Count stream checker: decodes up-wrap, down-wrap or triangle counting from a sample
// stream and reports lock, wrap/turn events, period length and illegal steps.
module count_stream_decoder #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             locked,
    output logic [1:0]       mode_out,
    output logic             wrap_pulse,
    output logic             turn_pulse,
    output logic             err_pulse,
    output logic [7:0]       err_count,
    output logic [WIDTH+1:0] period,
    output logic             period_valid
);

    localparam int unsigned LcW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] MaxV = '1;
    localparam logic [WIDTH+1:0] PerMax = '1;

    typedef enum logic [1:0] {StEmpty, StAcq, StLock} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic             dir_up_q;
    logic             dir_known_q;
    logic             seen_wrap_q;
    logic             seen_turn_q;
    logic             first_event_q;
    logic [LcW-1:0]   lock_cnt_q;
    logic [WIDTH+1:0] period_cnt_q;
    logic [WIDTH+1:0] period_q;
    logic             period_valid_q;
    logic [7:0]       err_count_q;
    logic             wrap_pulse_q;
    logic             turn_pulse_q;
    logic             err_pulse_q;

    // Step classification against the previous reference sample
    logic [WIDTH-1:0] delta;
    logic             is_hold, is_up, is_down;
    logic             up_turn, down_turn, turn_ok, wrap_ev;
    logic             illegal, legal_wrap, legal_turn, step, load;

    always_comb begin
        delta     = sample - prev_q;
        is_hold   = (delta == '0);
        is_up     = (delta == WIDTH'(1));
        is_down   = (delta == '1);
        up_turn   = is_up && dir_known_q && !dir_up_q;
        down_turn = is_down && dir_known_q && dir_up_q;
        turn_ok   = (up_turn && (prev_q == '0)) || (down_turn && (prev_q == MaxV));
        wrap_ev   = (is_up && !up_turn && (prev_q == MaxV)) ||
                    (is_down && !down_turn && (prev_q == '0));
        illegal   = !(is_up || is_down) ||
                    ((up_turn || down_turn) && !turn_ok) ||
                    (wrap_ev && seen_turn_q) ||
                    (turn_ok && seen_wrap_q);
        legal_wrap = wrap_ev && !illegal;
        legal_turn = turn_ok && !illegal;
        load       = sample_valid && (state_q == StEmpty);
        step       = sample_valid && !is_hold && (state_q != StEmpty);
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (sample_valid) state_d = StAcq;
            StAcq: begin
                if (step && !illegal && (lock_cnt_q == LcW'(LOCK_CNT - 1))) state_d = StLock;
            end
            StLock: if (step && illegal) state_d = StAcq;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            prev_q         <= '0;
            dir_up_q       <= 1'b0;
            dir_known_q    <= 1'b0;
            seen_wrap_q    <= 1'b0;
            seen_turn_q    <= 1'b0;
            first_event_q  <= 1'b0;
            lock_cnt_q     <= '0;
            period_cnt_q   <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            err_count_q    <= '0;
            wrap_pulse_q   <= 1'b0;
            turn_pulse_q   <= 1'b0;
            err_pulse_q    <= 1'b0;
        end else begin
            wrap_pulse_q <= 1'b0;
            turn_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            if (load) begin
                prev_q        <= sample;
                dir_known_q   <= 1'b0;
                seen_wrap_q   <= 1'b0;
                seen_turn_q   <= 1'b0;
                first_event_q <= 1'b0;
                lock_cnt_q    <= '0;
                period_cnt_q  <= '0;
            end else if (step) begin
                prev_q <= sample;
                if (illegal) begin
                    // The offending sample becomes the new reference for reacquisition
                    err_pulse_q    <= 1'b1;
                    if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                    dir_known_q    <= 1'b0;
                    seen_wrap_q    <= 1'b0;
                    seen_turn_q    <= 1'b0;
                    first_event_q  <= 1'b0;
                    lock_cnt_q     <= '0;
                    period_cnt_q   <= '0;
                    period_valid_q <= 1'b0;
                end else begin
                    dir_up_q    <= is_up;
                    dir_known_q <= 1'b1;
                    if (state_q == StAcq) lock_cnt_q <= lock_cnt_q + LcW'(1);
                    if (legal_wrap || legal_turn) begin
                        wrap_pulse_q  <= legal_wrap;
                        turn_pulse_q  <= legal_turn;
                        seen_wrap_q   <= seen_wrap_q | legal_wrap;
                        seen_turn_q   <= seen_turn_q | legal_turn;
                        period_q      <= (period_cnt_q == PerMax) ? PerMax
                                                                  : period_cnt_q + 1'b1;
                        period_cnt_q  <= '0;
                        first_event_q <= 1'b1;
                        if (first_event_q) period_valid_q <= 1'b1;
                    end else if (period_cnt_q != PerMax) begin
                        period_cnt_q <= period_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        locked   = (state_q == StLock);
        mode_out = 2'b00;
        if (locked) begin
            mode_out = seen_turn_q ? 2'b11 : (dir_up_q ? 2'b01 : 2'b10);
        end
    end

    assign wrap_pulse   = wrap_pulse_q;
    assign turn_pulse   = turn_pulse_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule

// File: tb/tb_count_stream_decoder.sv
// Directed bench for count_stream_decoder: up, down and triangle streams, errors,
// holds/gaps, error saturation and reset/clear while locked.
module tb_count_stream_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       sample_valid;
    logic [4:0] sample;
    logic       locked;
    logic [1:0] mode_out;
    logic       wrap_pulse;
    logic       turn_pulse;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [6:0] period;
    logic       period_valid;

    int checks   = 0;
    int failures = 0;

    count_stream_decoder #(.WIDTH(5), .LOCK_CNT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .locked       (locked),
        .mode_out     (mode_out),
        .wrap_pulse   (wrap_pulse),
        .turn_pulse   (turn_pulse),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int s);
        sample_valid = 1'b1;
        sample       = 5'(s);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle();
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic ramp(input int from, input int to);
        if (from <= to) begin
            for (int v = from; v <= to; v++) send(v);
        end else begin
            for (int v = from; v >= to; v--) send(v);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        idle();
        idle();
        check("rst_locked", locked, 0);
        check("rst_mode", mode_out, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_pvalid", period_valid, 0);
        check("rst_period", period, 0);
        reset = 1'b1;

        // Up ramp
        ramp(0, 3);
        check("up_not_locked_3", locked, 0);
        send(4);
        check("up_locked", locked, 1);
        check("up_mode", mode_out, 1);
        ramp(5, 31);
        send(0);
        check("up_wrap1", wrap_pulse, 1);
        check("up_wrap1_pvalid", period_valid, 0);
        send(1);
        check("up_wrap_deassert", wrap_pulse, 0);
        ramp(2, 31);
        send(0);
        check("up_wrap2", wrap_pulse, 1);
        check("up_period", period, 32);
        check("up_pvalid", period_valid, 1);
        check("up_errcnt", err_count, 0);

        // Clear while locked, then down ramp
        do_clear();
        check("clr_locked", locked, 0);
        check("clr_pvalid", period_valid, 0);
        check("clr_mode", mode_out, 0);
        ramp(10, 7);
        check("dn_not_locked", locked, 0);
        send(6);
        check("dn_locked", locked, 1);
        check("dn_mode", mode_out, 2);
        ramp(5, 0);
        send(31);
        check("dn_wrap", wrap_pulse, 1);
        send(30);
        check("dn_errcnt", err_count, 0);
        check("dn_mode2", mode_out, 2);

        // Triangle
        do_clear();
        ramp(0, 31);
        check("tri_mode_up", mode_out, 1);
        send(30);
        check("tri_turn1", turn_pulse, 1);
        check("tri_mode_tri", mode_out, 3);
        check("tri_pvalid0", period_valid, 0);
        ramp(29, 0);
        send(1);
        check("tri_turn2", turn_pulse, 1);
        check("tri_period", period, 31);
        check("tri_pvalid", period_valid, 1);
        ramp(2, 31);
        check("tri_errcnt", err_count, 0);

        // Error while locked and relock
        do_clear();
        ramp(0, 12);
        check("err_pre_locked", locked, 1);
        send(20);
        check("err_pulse", err_pulse, 1);
        check("err_count1", err_count, 1);
        check("err_unlocked", locked, 0);
        check("err_mode", mode_out, 0);
        ramp(21, 23);
        check("err_relock_early", locked, 0);
        send(24);
        check("err_relocked", locked, 1);
        check("err_relock_mode", mode_out, 1);
        send(5);
        check("err_count2", err_count, 2);
        send(6);
        send(5);
        check("err_reversal", err_pulse, 1);
        check("err_count3", err_count, 3);

        // Holds and gaps: prev=5 in ACQ with lock_cnt 0
        send(6);
        send(7);
        send(7);
        idle();
        send(7);
        idle();
        send(7);
        check("hold_errcnt", err_count, 3);
        check("hold_errpulse", err_pulse, 0);
        check("hold_locked", locked, 0);
        send(8);
        check("hold_lock_early", locked, 0);
        send(9);
        check("hold_locked_after", locked, 1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) send((i % 2) ? 16 : 0);
        check("sat_errcnt", err_count, 255);
        check("sat_errpulse", err_pulse, 1);

        // Reset while locked
        do_clear();
        ramp(0, 4);
        check("rst2_pre_locked", locked, 1);
        reset = 1'b0;
        send(9);
        reset = 1'b1;
        check("rst2_locked", locked, 0);
        check("rst2_mode", mode_out, 0);
        check("rst2_wrap", wrap_pulse, 0);
        check("rst2_errcnt", err_count, 0);
        send(3);
        check("rst2_load_err", err_pulse, 0);
        ramp(4, 6);
        check("rst2_acq", locked, 0);
        send(7);
        check("rst2_relocked", locked, 1);
        check("rst2_errcnt_end", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
